// File: rtl/cpu19_issue_if.sv
// Bundle between the cpu19 issue unit and its host/core: program load port, run control,
// and the issued instruction stream with status.
//
// Handshake: instr_valid qualifies instruction for exactly one cycle. There is no ready
// signal, so the core must take every word while instr_valid is high. When instr_valid is
// low, instruction carries NOP.
interface cpu19_issue_if #(
  parameter int AW = 8
);
  logic           prog_we;
  logic [AW-1:0]  prog_addr;
  logic [18:0]    prog_data;
  logic           start;
  logic           halt_req;
  logic           cond_eq;
  logic [18:0]    instruction;
  logic           instr_valid;
  logic           busy;
  logic           done;
  logic           error;
  logic [AW-1:0]  fetch_pc;
  logic [1:0]     state_dbg;

  // The issue unit side.
  modport master (
    input  prog_we, prog_addr, prog_data, start, halt_req, cond_eq,
    output instruction, instr_valid, busy, done, error, fetch_pc, state_dbg
  );

  // The host/core side.
  modport slave (
    output prog_we, prog_addr, prog_data, start, halt_req, cond_eq,
    input  instruction, instr_valid, busy, done, error, fetch_pc, state_dbg
  );
endinterface

// File: rtl/cpu19_issue_unit.sv
// Instruction issue unit for the 19-bit core: program memory, sequencer, return stack,
// and two-cycle conditional branch resolution using the core's compare flag.
module cpu19_issue_unit #(
  parameter int AW       = 8,
  parameter int STACK_AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  cpu19_issue_if.master bus
);
  localparam int          DEPTH       = 2 ** AW;
  localparam int          STACK_DEPTH = 2 ** STACK_AW;
  localparam logic [18:0] NOP         = 19'h7C000;
  localparam logic [4:0]  OP_JMP      = 5'b01010;
  localparam logic [4:0]  OP_BEQ      = 5'b01011;
  localparam logic [4:0]  OP_BNE      = 5'b01100;
  localparam logic [4:0]  OP_CALL     = 5'b01101;
  localparam logic [4:0]  OP_RET      = 5'b01110;
  localparam logic [4:0]  OP_HALT     = 5'b11110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    BR_WAIT = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [18:0]        mem   [DEPTH];
  logic [AW-1:0]      stack [STACK_DEPTH];
  logic [AW-1:0]      pc, pc_n;
  logic [STACK_AW:0]  sp, sp_n;
  logic [18:0]        instr, instr_n;
  logic               valid, valid_n;
  logic               busy_r;
  logic               done_r, done_n;
  logic               err_r, err_n;
  logic               br_is_beq, br_is_beq_n;
  logic [13:0]        br_imm, br_imm_n;
  logic               push, issue, fault, taken;
  logic [18:0]        word;
  logic [4:0]         opc;
  logic [13:0]        imm;
  logic [AW-1:0]      pc_inc;
  logic [AW-1:0]      stack_top;

  assign word      = mem[pc];
  assign opc       = word[18:14];
  assign imm       = word[13:0];
  assign pc_inc    = pc + AW'(1);
  assign stack_top = stack[STACK_AW'(sp - (STACK_AW + 1)'(1))];

  function automatic logic bad_target(input logic [13:0] t);
    return 32'(t) >= 32'(DEPTH);
  endfunction

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    sp_n        = sp;
    instr_n     = NOP;
    valid_n     = 1'b0;
    done_n      = done_r;
    err_n       = err_r;
    br_is_beq_n = br_is_beq;
    br_imm_n    = br_imm;
    push        = 1'b0;
    issue       = 1'b0;
    fault       = 1'b0;
    taken       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          pc_n    = '0;
          sp_n    = '0;
          done_n  = 1'b0;
          err_n   = 1'b0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (bus.halt_req) begin
          done_n  = 1'b1;
          err_n   = 1'b0;
          state_n = IDLE;
        end else begin
          case (opc)
            OP_JMP: begin
              if (bad_target(imm)) fault = 1'b1;
              else begin
                issue = 1'b1;
                pc_n  = AW'(imm);
              end
            end
            OP_CALL: begin
              if (bad_target(imm) || sp == (STACK_AW + 1)'(STACK_DEPTH)) fault = 1'b1;
              else begin
                issue = 1'b1;
                push  = 1'b1;
                sp_n  = sp + (STACK_AW + 1)'(1);
                pc_n  = AW'(imm);
              end
            end
            OP_RET: begin
              if (sp == '0) fault = 1'b1;
              else begin
                issue = 1'b1;
                sp_n  = sp - (STACK_AW + 1)'(1);
                pc_n  = stack_top;
              end
            end
            OP_BEQ, OP_BNE: begin
              issue       = 1'b1;
              br_is_beq_n = (opc == OP_BEQ);
              br_imm_n    = imm;
              state_n     = BR_WAIT;
            end
            OP_HALT: begin
              done_n  = 1'b1;
              state_n = IDLE;
            end
            default: begin
              issue = 1'b1;
              pc_n  = pc_inc;
            end
          endcase
        end
      end
      BR_WAIT: begin
        // pc still points at the branch word, so pc_inc is the fall-through address.
        if (bus.halt_req) begin
          done_n  = 1'b1;
          err_n   = 1'b0;
          state_n = IDLE;
        end else begin
          taken = br_is_beq ? bus.cond_eq : ~bus.cond_eq;
          if (taken && bad_target(br_imm)) fault = 1'b1;
          else begin
            pc_n    = taken ? AW'(br_imm) : pc_inc;
            state_n = RUN;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (issue) begin
      instr_n = word;
      valid_n = 1'b1;
    end
    if (fault) begin
      done_n  = 1'b1;
      err_n   = 1'b1;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      sp        <= '0;
      instr     <= NOP;
      valid     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      br_is_beq <= 1'b0;
      br_imm    <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      sp        <= sp_n;
      instr     <= instr_n;
      valid     <= valid_n;
      busy_r    <= (state_n != IDLE);
      done_r    <= done_n;
      err_r     <= err_n;
      br_is_beq <= br_is_beq_n;
      br_imm    <= br_imm_n;
    end
  end

  // Program memory and return stack hold their contents across reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk) begin
    if (push) stack[sp[STACK_AW-1:0]] <= pc_inc;
  end

  assign bus.instruction = instr;
  assign bus.instr_valid = valid;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.error       = err_r;
  assign bus.fetch_pc    = pc;
  assign bus.state_dbg   = state;
endmodule

// File: tb/tb_cpu19_issue_unit.sv
// Directed bench for cpu19_issue_unit: loads small programs, runs them and scores the
// issued word stream against an expected queue plus status flags.
module tb_cpu19_issue_unit;
  localparam int          AW      = 8;
  localparam logic [18:0] NOP     = 19'h7C000;
  localparam logic [4:0]  OP_ADD  = 5'b00001;
  localparam logic [4:0]  OP_SUB  = 5'b00010;
  localparam logic [4:0]  OP_INC  = 5'b00011;
  localparam logic [4:0]  OP_JMP  = 5'b01010;
  localparam logic [4:0]  OP_BEQ  = 5'b01011;
  localparam logic [4:0]  OP_BNE  = 5'b01100;
  localparam logic [4:0]  OP_CALL = 5'b01101;
  localparam logic [4:0]  OP_RET  = 5'b01110;
  localparam logic [4:0]  OP_HALT = 5'b11110;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int            checks = 0;
  int            errors = 0;
  logic [18:0]   exp_q[$];
  int            issue_cyc[$];
  logic [AW-1:0] issue_pc[$];

  cpu19_issue_if #(.AW(AW)) bus ();

  cpu19_issue_unit #(.AW(AW), .STACK_AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input logic [4:0] op, input logic [13:0] imm);
    return {op, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [18:0] d);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    @(negedge clk);
    bus.prog_we   = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e);
    chk({tag, "_done"},  32'(bus.done),        32'(d));
    chk({tag, "_error"}, 32'(bus.error),       32'(e));
    chk({tag, "_busy"},  32'(bus.busy),        32'(0));
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'(0));
    chk({tag, "_nop"},   32'(bus.instruction), 32'(NOP));
  endtask

  // Pulses start, scores every issued word against exp_q until busy drops.
  task automatic run(input string tag, input int budget, input int halt_at);
    bit finished;
    finished = 1'b0;
    issue_cyc.delete();
    issue_pc.delete();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      bus.halt_req = 1'b0;
      if (bus.instr_valid) begin
        issue_cyc.push_back(cyc);
        issue_pc.push_back(bus.fetch_pc);
        if (exp_q.size() == 0) chk({tag, "_extra"}, 32'(bus.instr_valid), 32'(0));
        else chk({tag, "_word"}, 32'(bus.instruction), 32'(exp_q.pop_front()));
      end
      if (!bus.busy) begin
        finished = 1'b1;
        break;
      end
      if (cyc == halt_at) bus.halt_req = 1'b1;
    end
    bus.halt_req = 1'b0;
    chk({tag, "_finished"}, 32'(finished), 32'(1));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start     = 1'b0;
    bus.halt_req  = 1'b0;
    bus.cond_eq   = 1'b0;

    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_status("reset", 1'b0, 1'b0);
    chk("reset_pc", 32'(bus.fetch_pc), 32'(0));

    // straight-line: ADD, SUB, HALT
    load(0, mk(OP_ADD, 14'h011));
    load(1, mk(OP_SUB, 14'h022));
    load(2, mk(OP_HALT, 14'h000));
    exp_q.push_back(mk(OP_ADD, 14'h011));
    exp_q.push_back(mk(OP_SUB, 14'h022));
    run("seq", 20, 0);
    chk("seq_count", 32'(issue_cyc.size()), 32'(2));
    if (issue_cyc.size() == 2) begin
      chk("seq_latency", 32'(issue_cyc[0]), 32'(1));
      chk("seq_back2back", 32'(issue_cyc[1]), 32'(2));
    end
    check_status("seq", 1'b1, 1'b0);

    // JMP 5 -> INC -> HALT
    load(0, mk(OP_JMP, 14'd5));
    load(5, mk(OP_INC, 14'h005));
    load(6, mk(OP_HALT, 14'h000));
    exp_q.push_back(mk(OP_JMP, 14'd5));
    exp_q.push_back(mk(OP_INC, 14'h005));
    run("jmp", 20, 0);
    if (issue_pc.size() == 2) chk("jmp_pc", 32'(issue_pc[0]), 32'(5));
    check_status("jmp", 1'b1, 1'b0);

    // BEQ 9, taken then not taken
    load(0, mk(OP_BEQ, 14'd9));
    load(1, mk(OP_SUB, 14'h101));
    load(2, mk(OP_HALT, 14'h000));
    load(9, mk(OP_ADD, 14'h109));
    load(10, mk(OP_HALT, 14'h000));
    bus.cond_eq = 1'b1;
    exp_q.push_back(mk(OP_BEQ, 14'd9));
    exp_q.push_back(mk(OP_ADD, 14'h109));
    run("beq_t", 20, 0);
    if (issue_cyc.size() == 2) chk("beq_t_bubble", 32'(issue_cyc[1] - issue_cyc[0]), 32'(2));
    bus.cond_eq = 1'b0;
    exp_q.push_back(mk(OP_BEQ, 14'd9));
    exp_q.push_back(mk(OP_SUB, 14'h101));
    run("beq_n", 20, 0);
    if (issue_cyc.size() == 2) chk("beq_n_bubble", 32'(issue_cyc[1] - issue_cyc[0]), 32'(2));
    check_status("beq_n", 1'b1, 1'b0);

    // BNE taken to an out-of-range target faults after the branch issues
    load(0, mk(OP_BNE, 14'h3FFF));
    exp_q.push_back(mk(OP_BNE, 14'h3FFF));
    run("bne_bad", 20, 0);
    check_status("bne_bad", 1'b1, 1'b1);

    // CALL 20 from address 3, RET returns to 4
    load(0, mk(OP_ADD, 14'h000));
    load(1, mk(OP_SUB, 14'h001));
    load(2, mk(OP_INC, 14'h002));
    load(3, mk(OP_CALL, 14'd20));
    load(4, mk(OP_ADD, 14'h004));
    load(5, mk(OP_HALT, 14'h000));
    load(20, mk(OP_INC, 14'h014));
    load(21, mk(OP_RET, 14'h000));
    exp_q.push_back(mk(OP_ADD, 14'h000));
    exp_q.push_back(mk(OP_SUB, 14'h001));
    exp_q.push_back(mk(OP_INC, 14'h002));
    exp_q.push_back(mk(OP_CALL, 14'd20));
    exp_q.push_back(mk(OP_INC, 14'h014));
    exp_q.push_back(mk(OP_RET, 14'h000));
    exp_q.push_back(mk(OP_ADD, 14'h004));
    run("call", 30, 0);
    check_status("call", 1'b1, 1'b0);

    // 17 nested CALLs: the 17th overflows the 16-entry stack
    for (int k = 0; k <= 16; k++) load(AW'(k), mk(OP_CALL, 14'(k + 1)));
    for (int k = 0; k < 16; k++) exp_q.push_back(mk(OP_CALL, 14'(k + 1)));
    run("ovf", 40, 0);
    chk("ovf_count", 32'(issue_cyc.size()), 32'(16));
    check_status("ovf", 1'b1, 1'b1);

    // RET with empty stack
    load(0, mk(OP_RET, 14'h000));
    run("ret_empty", 20, 0);
    chk("ret_empty_count", 32'(issue_cyc.size()), 32'(0));
    check_status("ret_empty", 1'b1, 1'b1);

    // JMP beyond DEPTH
    load(0, mk(OP_JMP, 14'd300));
    run("jmp_bad", 20, 0);
    chk("jmp_bad_count", 32'(issue_cyc.size()), 32'(0));
    check_status("jmp_bad", 1'b1, 1'b1);

    // reset two cycles into a looping run
    load(0, mk(OP_ADD, 14'h0A0));
    load(1, mk(OP_SUB, 14'h0A1));
    load(2, mk(OP_INC, 14'h0A2));
    load(3, mk(OP_JMP, 14'd0));
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_first", 32'(bus.instruction), 32'(mk(OP_ADD, 14'h0A0)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_status("rst_mid", 1'b0, 1'b0);
    chk("rst_mid_pc", 32'(bus.fetch_pc), 32'(0));

    // restart after reset, then halt_req ends the loop cleanly
    exp_q.push_back(mk(OP_ADD, 14'h0A0));
    exp_q.push_back(mk(OP_SUB, 14'h0A1));
    exp_q.push_back(mk(OP_INC, 14'h0A2));
    exp_q.push_back(mk(OP_JMP, 14'd0));
    exp_q.push_back(mk(OP_ADD, 14'h0A0));
    exp_q.push_back(mk(OP_SUB, 14'h0A1));
    run("halt", 20, 6);
    chk("halt_count", 32'(issue_cyc.size()), 32'(6));
    check_status("halt", 1'b1, 1'b0);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
